// File: rtl/grom8_mem_pkg.sv
// Shared definitions for the grom8 byte-wide memory path: address spaces,
// page constants, mem_master state codes and address helpers.
package grom8_mem_pkg;

  localparam int MEM_AW = 12;

  localparam logic [1:0] SPACE_ABS   = 2'd0;
  localparam logic [1:0] SPACE_DATA  = 2'd1;
  localparam logic [1:0] SPACE_STACK = 2'd2;

  localparam logic [3:0] DATA_PAGE  = 4'hD;
  localparam logic [3:0] STACK_PAGE = 4'hF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACC0 = 3'd1;
  localparam logic [2:0] ST_CAP0 = 3'd2;
  localparam logic [2:0] ST_ACC1 = 3'd3;
  localparam logic [2:0] ST_CAP1 = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  // Effective address of the first byte; the reserved space code behaves as absolute.
  function automatic logic [MEM_AW-1:0] ea_calc(
    input logic [1:0]        space,
    input logic [MEM_AW-1:0] addr,
    input logic [3:0]        dpage,
    input logic [3:0]        spage
  );
    logic [MEM_AW-1:0] ea;
    case (space)
      SPACE_DATA:  ea = {dpage, addr[7:0]};
      SPACE_STACK: ea = {spage, addr[7:0]};
      default:     ea = addr;
    endcase
    return ea;
  endfunction

  // Second-byte address: paged spaces wrap inside their 256-byte page.
  function automatic logic [MEM_AW-1:0] ea_next(
    input logic [1:0]        space,
    input logic [MEM_AW-1:0] ea
  );
    logic [MEM_AW-1:0] nxt;
    if (space == SPACE_DATA || space == SPACE_STACK) begin
      nxt = {ea[MEM_AW-1:8], ea[7:0] + 8'd1};
    end else begin
      nxt = ea + MEM_AW'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// CPU request/response and RAM port signals of mem_master, bundled with
// modports for the initiator (master) and its environment (slave).
interface mem_master_if #(
  parameter int ADDR_W = 12
) ();

  logic              req;
  logic              wr;
  logic              word;
  logic [1:0]        space;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              busy;
  logic              done;
  logic              memreq;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    input  req, wr, word, space, addr, wdata, mem_rdata,
    output rdata, busy, done, memreq, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, wr, word, space, addr, wdata, mem_rdata,
    input  rdata, busy, done, memreq, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_master.sv
// CPU-side initiator for the grom8 byte RAM: splits a load/store into one or
// two byte transactions with page selection; all outputs come from flops.
module mem_master #(
  parameter int         ADDR_W     = 12,
  parameter logic [3:0] DATA_PAGE  = 4'hD,
  parameter logic [3:0] STACK_PAGE = 4'hF
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_master_if.master  bus
);

  import grom8_mem_pkg::*;

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [ADDR_W-1:0] ea1_q, ea1_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              memreq_q, memreq_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] ea_in_s;

  // Page selection of the incoming CPU address.
  always_comb begin
    ea_in_s = ea_calc(bus.space, bus.addr, DATA_PAGE, STACK_PAGE);
  end

  // Transaction sequencing, request latching and read-data capture.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    word_d  = word_q;
    ea_d    = ea_q;
    ea1_d   = ea1_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          word_d  = bus.word;
          ea_d    = ea_in_s;
          ea1_d   = ea_next(bus.space, ea_in_s);
          wdata_d = bus.wdata;
          rdata_d = 16'h0000;
          state_d = ST_ACC0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC0: begin
        if (!wr_q) begin
          state_d = ST_CAP0;
        end else if (word_q) begin
          state_d = ST_ACC1;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_CAP0: begin
        rdata_d[7:0] = bus.mem_rdata;
        if (word_q) begin
          state_d = ST_ACC1;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_ACC1: begin
        if (!wr_q) begin
          state_d = ST_CAP1;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_CAP1: begin
        rdata_d[15:8] = bus.mem_rdata;
        state_d       = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so they
  // can be registered without adding a cycle of latency.
  always_comb begin
    memreq_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      ST_ACC0: begin
        memreq_d    = 1'b1;
        mem_addr_d  = ea_d;
        mem_wdata_d = wdata_d[7:0];
      end
      ST_ACC1: begin
        memreq_d    = 1'b1;
        mem_addr_d  = ea1_d;
        mem_wdata_d = wdata_d[15:8];
      end
      default: begin
        memreq_d = 1'b0;
      end
    endcase
    mem_we_d = memreq_d & wr_d;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FIN);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      word_q      <= 1'b0;
      ea_q        <= '0;
      ea1_q       <= '0;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      memreq_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      word_q      <= word_d;
      ea_q        <= ea_d;
      ea1_q       <= ea1_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      memreq_q    <= memreq_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.memreq    = memreq_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
